hazard_scoreboard: RTL and testbench

//  Parametrised hazard controller for the non-forwarding 5-stage RV32 pipeline.

---
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the non-forwarding 5-stage RV32 pipeline.
// Tracks in-flight writers per register and drives stall/flush controls and perf counters.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int MAX_INFLIGHT = 3,
  parameter bit WB_BYPASS    = 1'b1,
  parameter int PERF_W       = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid_d,
  input  logic [REG_AW-1:0]   i_rs1_d,
  input  logic [REG_AW-1:0]   i_rs2_d,
  input  logic                i_rs1_used_d,
  input  logic                i_rs2_used_d,
  input  logic [REG_AW-1:0]   i_rd_d,
  input  logic                i_rd_wren_d,
  input  logic                i_retire_w,
  input  logic [REG_AW-1:0]   i_rd_w,
  input  logic                i_br_taken,
  input  logic                i_mem_busy,
  output logic                o_stall_pc,
  output logic                o_stall_f,
  output logic                o_stall_d,
  output logic                o_stall_e,
  output logic                o_stall_m,
  output logic                o_flush_f,
  output logic                o_flush_d,
  output logic                o_flush_e,
  output logic [NUM_REGS-1:0] o_busy_mask,
  output logic [PERF_W-1:0]   o_hazard_cnt,
  output logic [PERF_W-1:0]   o_flush_cnt,
  output logic                o_err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic                raw;
  logic                issue;
  logic                range_err;

  // A register whose last writer retires this cycle is readable through the RF write-through.
  always_comb begin
    busy_vec    = '0;
    o_busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      o_busy_mask[r] = (cnt[r] != '0);
      busy_vec[r]    = (cnt[r] != '0) &&
                       !(WB_BYPASS && i_retire_w && (i_rd_w == REG_AW'(r)) && (cnt[r] == CW'(1)));
    end
  end

  assign raw   = i_valid_d && ((i_rs1_used_d && busy_vec[i_rs1_d]) ||
                               (i_rs2_used_d && busy_vec[i_rs2_d]));
  assign issue = i_valid_d && i_rd_wren_d && (i_rd_d != '0) && !raw && !i_br_taken && !i_mem_busy;

  always_comb begin
    o_stall_pc = 1'b0;
    o_stall_f  = 1'b0;
    o_stall_d  = 1'b0;
    o_stall_e  = 1'b0;
    o_stall_m  = 1'b0;
    o_flush_f  = 1'b0;
    o_flush_d  = 1'b0;
    o_flush_e  = 1'b0;
    if (!i_rst) begin
      if (i_mem_busy) begin
        o_stall_pc = 1'b1;
        o_stall_f  = 1'b1;
        o_stall_d  = 1'b1;
        o_stall_e  = 1'b1;
        o_stall_m  = 1'b1;
      end else if (i_br_taken) begin
        o_flush_f = 1'b1;
        o_flush_d = 1'b1;
      end else if (raw) begin
        o_stall_pc = 1'b1;
        o_stall_f  = 1'b1;
        o_stall_d  = 1'b1;
        o_flush_e  = 1'b1;
      end
    end
  end

  // x0 is excluded from both directions, so cnt[0] never leaves zero.
  always_comb begin
    inc       = '0;
    dec       = '0;
    range_err = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = issue && (i_rd_d == REG_AW'(r));
      dec[r] = i_retire_w && (i_rd_w == REG_AW'(r));
      if (inc[r] && !dec[r] && (cnt[r] == CW'(MAX_INFLIGHT))) range_err = 1'b1;
      if (dec[r] && !inc[r] && (cnt[r] == '0)) range_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      o_hazard_cnt <= '0;
      o_flush_cnt  <= '0;
      o_err        <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r] && (cnt[r] != CW'(MAX_INFLIGHT)))
          cnt[r] <= cnt[r] + CW'(1);
        else if (dec[r] && !inc[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CW'(1);
      end
      if (o_flush_e && (o_hazard_cnt != '1)) o_hazard_cnt <= o_hazard_cnt + PERF_W'(1);
      if (o_flush_d && (o_flush_cnt != '1))  o_flush_cnt  <= o_flush_cnt + PERF_W'(1);
      o_err <= o_err | range_err;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline scenarios plus a random pipeline,
// expectations from a register-count reference model, checked by a decoupled monitor.
module tb_hazard_scoreboard;

  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic          i_clk;
  logic          i_rst;
  logic          i_valid_d;
  logic [4:0]    i_rs1_d;
  logic [4:0]    i_rs2_d;
  logic          i_rs1_used_d;
  logic          i_rs2_used_d;
  logic [4:0]    i_rd_d;
  logic          i_rd_wren_d;
  logic          i_retire_w;
  logic [4:0]    i_rd_w;
  logic          i_br_taken;
  logic          i_mem_busy;
  logic          o_stall_pc, o_stall_f, o_stall_d, o_stall_e, o_stall_m;
  logic          o_flush_f, o_flush_d, o_flush_e;
  logic [31:0]   o_busy_mask;
  logic [PW-1:0] o_hazard_cnt;
  logic [PW-1:0] o_flush_cnt;
  logic          o_err;

  hazard_scoreboard #(
    .NUM_REGS(32), .REG_AW(5), .MAX_INFLIGHT(3), .WB_BYPASS(1'b1), .PERF_W(PW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_d(i_valid_d),
    .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d),
    .i_rs1_used_d(i_rs1_used_d), .i_rs2_used_d(i_rs2_used_d),
    .i_rd_d(i_rd_d), .i_rd_wren_d(i_rd_wren_d),
    .i_retire_w(i_retire_w), .i_rd_w(i_rd_w),
    .i_br_taken(i_br_taken), .i_mem_busy(i_mem_busy),
    .o_stall_pc(o_stall_pc), .o_stall_f(o_stall_f), .o_stall_d(o_stall_d),
    .o_stall_e(o_stall_e), .o_stall_m(o_stall_m),
    .o_flush_f(o_flush_f), .o_flush_d(o_flush_d), .o_flush_e(o_flush_e),
    .o_busy_mask(o_busy_mask), .o_hazard_cnt(o_hazard_cnt),
    .o_flush_cnt(o_flush_cnt), .o_err(o_err)
  );

  typedef struct {
    logic [4:0]  stall;
    logic [2:0]  flush;
    logic [31:0] mask;
    int          hz;
    int          fl;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: in-flight writer count per register plus perf/err state.
  int   m_cnt[32];
  int   m_hz, m_fl;
  bit   m_err;
  bit   m_raw;
  bit   rst_q;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("stall", {o_stall_pc, o_stall_f, o_stall_d, o_stall_e, o_stall_m}, mon_e.stall);
      checkOutput("flush", {o_flush_f, o_flush_d, o_flush_e}, mon_e.flush);
      checkOutput("busy_mask", o_busy_mask, mon_e.mask);
      checkOutput("hazard_cnt", o_hazard_cnt, mon_e.hz);
      checkOutput("flush_cnt", o_flush_cnt, mon_e.fl);
      checkOutput("err", o_err, mon_e.err);
    end
  end

  function automatic bit modelBusy(input int r, input bit ret, input int rdw);
    return (r != 0) && (m_cnt[r] > 0) && !(ret && (rdw == r) && (m_cnt[r] == 1));
  endfunction

  task automatic applyStimulus(input bit v, input int r1, input int r2, input bit u1,
                               input bit u2, input int rd, input bit wr, input bit ret,
                               input int rdw, input bit br, input bit mb);
    exp_t e;
    bit   iss;
    @(posedge i_clk);
    #1;
    i_rst        = rst_q;
    i_valid_d    = v;
    i_rs1_d      = 5'(r1);
    i_rs2_d      = 5'(r2);
    i_rs1_used_d = u1;
    i_rs2_used_d = u2;
    i_rd_d       = 5'(rd);
    i_rd_wren_d  = wr;
    i_retire_w   = ret;
    i_rd_w       = 5'(rdw);
    i_br_taken   = br;
    i_mem_busy   = mb;
    if (rst_q) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_hz  = 0;
      m_fl  = 0;
      m_err = 1'b0;
    end
    m_raw   = v && ((u1 && modelBusy(r1, ret, rdw)) || (u2 && modelBusy(r2, ret, rdw)));
    e.stall = '0;
    e.flush = '0;
    if (!rst_q) begin
      if (mb) e.stall = 5'b11111;
      else if (br) e.flush = 3'b110;
      else if (m_raw) begin
        e.stall = 5'b11100;
        e.flush = 3'b001;
      end
    end
    e.mask = '0;
    for (int r = 1; r < 32; r++) e.mask[r] = (m_cnt[r] != 0);
    e.hz  = m_hz;
    e.fl  = m_fl;
    e.err = m_err;
    exp_q.push_back(e);
    if (!rst_q) begin
      iss = v && wr && (rd != 0) && !m_raw && !br && !mb;
      for (int r = 1; r < 32; r++) begin
        if (iss && rd == r && !(ret && rdw == r)) begin
          if (m_cnt[r] == 3) m_err = 1'b1;
          else m_cnt[r]++;
        end else if (ret && rdw == r && !(iss && rd == r)) begin
          if (m_cnt[r] == 0) m_err = 1'b1;
          else m_cnt[r]--;
        end
      end
      if (e.flush[0] && m_hz < PMAX) m_hz++;
      if (e.flush[1] && m_fl < PMAX) m_fl++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writeReg(input int rd);
    applyStimulus(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0);
  endtask

  task automatic retireOnly(input int rdw);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, rdw, 0, 0);
  endtask

  // Random pipeline: E/M/W hold in-flight writers, D is a random instruction.
  task automatic randomPhase(input int cycles);
    bit e_v = 0, m_v = 0, w_v = 0, br_hold = 0;
    int e_rd = 0, m_rd = 0, w_rd = 0;
    bit dv, du1, du2, dwr, ret, br, mb;
    int d1, d2, drd, rdw;
    dv = 0; du1 = 0; du2 = 0; dwr = 0; d1 = 0; d2 = 0; drd = 0;
    for (int c = 0; c < cycles; c++) begin
      ret = w_v;
      rdw = w_rd;
      mb  = ($urandom_range(0, 7) == 0);
      br  = br_hold ? 1'b1 : ($urandom_range(0, 9) == 0);
      applyStimulus(dv, d1, d2, du1, du2, drd, dwr, ret, rdw, br, mb);
      w_v = 1'b0;
      if (mb) br_hold = br;
      else begin
        br_hold = 1'b0;
        w_v = m_v; w_rd = m_rd;
        m_v = e_v; m_rd = e_rd;
        if (br || m_raw || !dv) e_v = 1'b0;
        else begin
          e_v  = dwr;
          e_rd = drd;
        end
        if (!m_raw || br) begin
          dv  = ($urandom_range(0, 3) != 0);
          d1  = $urandom_range(0, 7);
          d2  = $urandom_range(0, 7);
          du1 = $urandom_range(0, 1);
          du2 = $urandom_range(0, 1);
          drd = $urandom_range(0, 7);
          dwr = ($urandom_range(0, 3) != 0);
        end
      end
    end
  endtask

  initial begin
    rst_q = 1'b1;
    i_rst = 1'b1;
    i_valid_d = 0; i_rs1_d = 0; i_rs2_d = 0; i_rs1_used_d = 0; i_rs2_used_d = 0;
    i_rd_d = 0; i_rd_wren_d = 0; i_retire_w = 0; i_rd_w = 0; i_br_taken = 0; i_mem_busy = 0;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_hz = 0; m_fl = 0; m_err = 0; m_raw = 0;
    $display("[TB] start");
    idle(2);
    rst_q = 1'b0;
    idle(1);

    // Dependent ALU pair: two bubble cycles, released when x5 retires.
    writeReg(5);
    applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0);
    applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0);
    applyStimulus(1, 5, 5, 1, 1, 6, 1, 1, 5, 0, 0);
    idle(2);
    retireOnly(6);

    // Three writers of x7 in flight; reader waits for the third retire.
    writeReg(7);
    writeReg(7);
    writeReg(7);
    applyStimulus(1, 7, 0, 1, 0, 8, 1, 1, 7, 0, 0);
    applyStimulus(1, 7, 0, 1, 0, 8, 1, 1, 7, 0, 0);
    applyStimulus(1, 7, 0, 1, 0, 8, 1, 1, 7, 0, 0);
    idle(3);
    retireOnly(8);

    // Taken branch with a RAW-hazarded D instruction.
    writeReg(10);
    applyStimulus(1, 10, 0, 1, 0, 11, 1, 0, 0, 1, 0);
    idle(1);
    retireOnly(10);

    // Memory freeze with a pending branch, flush once memory is ready.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, 0, 12, 1, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 1, 0, 12, 1, 0, 0, 1, 0);
    idle(2);

    // Fourth writer of x13 overflows the counter.
    for (int i = 0; i < 4; i++) writeReg(13);
    idle(2);

    // Async reset mid-run with two writers of x5 in flight and a reader in D.
    writeReg(5);
    writeReg(5);
    rst_q = 1'b1;
    applyStimulus(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
    applyStimulus(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
    rst_q = 1'b0;
    idle(1);

    // x0 is never tracked; retire of an idle x9 raises the sticky error.
    applyStimulus(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    retireOnly(9);
    idle(3);

    rst_q = 1'b1;
    idle(1);
    rst_q = 1'b0;
    randomPhase(600);
    idle(4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge i_clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
